// File: rtl/hex_value_scanner_pkg.sv
// Shared state encoding, blank pattern and a small helper for the hex value scanner.
package hex_value_scanner_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHOW    = 2'd1;
    localparam logic [1:0] S_GAP     = 2'd2;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SHOW = S_SHOW,
        ST_GAP  = S_GAP
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_value_scanner_if.sv
// Control/data bundle between the counter datapath and the seven-segment scanner.
interface hex_value_scanner_if;
    logic        enable;
    logic [31:0] value;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic [2:0]  digit_idx;

    modport master (output enable, value, input seg, dp, busy, digit_idx);
    modport slave  (input enable, value, output seg, dp, busy, digit_idx);
endinterface

// File: rtl/hex_value_scanner_seg7.sv
// Combinational hex nibble to seven-segment decoder (segments a..g on bits 0..6).
module hex_value_scanner_seg7 (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/hex_value_scanner.sv
// Scans a snapshot of the counter word onto one seven-segment digit, MSB nibble
// first with leading zeros suppressed, blank gaps between digits, dp on the first.
module hex_value_scanner
    import hex_value_scanner_pkg::*;
#(
    parameter int NIBBLES      = 8,
    parameter int DWELL_CYCLES = 1000000,
    parameter int GAP_CYCLES   = 250000
) (
    input  logic              clk,
    input  logic              reset,
    hex_value_scanner_if.slave bus
);
    localparam int VW    = 4 * NIBBLES;
    localparam int CNT_W = $clog2(max_u(DWELL_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYCLES - 1);

    state_t           r_state, w_state_next;
    logic [VW-1:0]    r_snap, w_snap_next, w_value;
    logic [CNT_W-1:0] r_timer, w_timer_next;
    logic [2:0]       r_idx, w_idx_next, w_lead;
    logic             r_first, w_first_next;
    logic [6:0]       r_seg, w_seg_next, w_dec;
    logic             r_dp, w_dp_next, r_busy, w_busy_next;
    logic [NIBBLES-1:0] w_nz;
    logic [3:0]       w_nib [NIBBLES];
    logic [3:0]       w_dec_nib;

    assign w_value = bus.value[VW-1:0];

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_nz[gi]  = |w_value[4*gi +: 4];
            assign w_nib[gi] = w_snap_next[4*gi +: 4];
        end
    endgenerate

    // Highest nonzero nibble wins; an all-zero word still shows nibble 0.
    always_comb begin
        w_lead = 3'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (w_nz[i]) w_lead = 3'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_snap_next  = r_snap;
        w_timer_next = r_timer;
        w_idx_next   = r_idx;
        w_first_next = r_first;
        case (r_state)
            ST_IDLE: begin
                if (w_value != r_snap) begin
                    w_snap_next  = w_value;
                    w_idx_next   = w_lead;
                    w_timer_next = '0;
                    w_first_next = 1'b1;
                    w_state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_timer == DWELL_TC) begin
                    w_timer_next = '0;
                    if (r_idx == 3'd0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_GAP;
                        w_idx_next   = r_idx - 3'd1;
                        w_first_next = 1'b0;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_timer == GAP_TC) begin
                    w_timer_next = '0;
                    w_state_next = ST_SHOW;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so a new digit appears on the same edge.
    assign w_dec_nib   = (w_state_next == ST_SHOW) ? w_nib[w_idx_next] : w_nib[0];
    assign w_seg_next  = (w_state_next == ST_GAP) ? SEG_BLANK : w_dec;
    assign w_dp_next   = (w_state_next == ST_SHOW) && w_first_next;
    assign w_busy_next = (w_state_next != ST_IDLE);

    hex_value_scanner_seg7 u_seg7 (
        .i_nibble (w_dec_nib),
        .o_seg    (w_dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_snap  <= '0;
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_first <= 1'b0;
            r_seg   <= 7'h3F;
            r_dp    <= 1'b0;
            r_busy  <= 1'b0;
        end else if (bus.enable) begin
            r_state <= w_state_next;
            r_snap  <= w_snap_next;
            r_timer <= w_timer_next;
            r_idx   <= w_idx_next;
            r_first <= w_first_next;
            r_seg   <= w_seg_next;
            r_dp    <= w_dp_next;
            r_busy  <= w_busy_next;
        end
    end

    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.busy      = r_busy;
    assign bus.digit_idx = r_idx;

endmodule

// File: tb/tb_hex_value_scanner.sv
// Bench for hex_value_scanner: per-digit schedule model checked every cycle,
// plus directed checks with hand-computed segment patterns.
module tb_hex_value_scanner;
    localparam int DW = 4;
    localparam int GW = 2;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic       busy;
        logic [2:0] idx;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    hex_value_scanner_if bus_if ();

    hex_value_scanner #(
        .NIBBLES      (8),
        .DWELL_CYCLES (DW),
        .GAP_CYCLES   (GW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic obs_t idle_obs(input logic [31:0] s);
        return obs_t'{SEG_TAB[s[3:0]], 1'b0, 1'b0, 3'd0};
    endfunction

    obs_t        q [$];
    logic [31:0] m_snap = 32'h0;
    obs_t        m_exp  = obs_t'{7'h3F, 1'b0, 1'b0, 3'd0};

    // Whole-sequence schedule: one entry per cycle of output after each edge.
    task automatic build(input logic [31:0] v);
        int         lead;
        logic [3:0] nib;
        lead = 0;
        for (int i = 0; i < 8; i++)
            if (((v >> (4 * i)) & 32'hF) != 0) lead = i;
        for (int k = lead; k >= 0; k--) begin
            nib = 4'((v >> (4 * k)) & 32'hF);
            repeat (DW) q.push_back(obs_t'{SEG_TAB[nib], (k == lead), 1'b1, 3'(k)});
            if (k > 0) repeat (GW) q.push_back(obs_t'{7'h00, 1'b0, 1'b1, 3'(k - 1)});
        end
        q.push_back(idle_obs(v));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] dut_obs();
        return 32'({bus_if.seg, bus_if.dp, bus_if.busy, bus_if.digit_idx});
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_snap = 32'h0;
                m_exp  = idle_obs(32'h0);
            end else if (bus_if.enable) begin
                if (q.size() == 0 && bus_if.value != m_snap) begin
                    m_snap = bus_if.value;
                    build(bus_if.value);
                end
                if (q.size() > 0) m_exp = q.pop_front();
                else              m_exp = idle_obs(m_snap);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cycle_model", dut_obs(), 32'(m_exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bus_if.enable = 1'b1;
        bus_if.value  = 32'h0;
        tick(3);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t1_idle", dut_obs(), 32'({7'h3F, 1'b0, 1'b0, 3'd0}));
        end
        $display("T1 idle after reset checked");

        bus_if.value = 32'h000000A5;
        tick(1);
        check("t2_first", dut_obs(), 32'({7'h77, 1'b1, 1'b1, 3'd1}));
        tick(4);
        check("t2_gap", 32'(bus_if.seg), 32'h00);
        tick(2);
        check("t2_second", dut_obs(), 32'({7'h6D, 1'b0, 1'b1, 3'd0}));
        tick(4);
        check("t2_idle", dut_obs(), 32'({7'h6D, 1'b0, 1'b0, 3'd0}));
        $display("T2 value A5 sequence checked");

        bus_if.value = 32'h80000001;
        tick(1);
        check("t3_first", dut_obs(), 32'({7'h7F, 1'b1, 1'b1, 3'd7}));
        cnt = 1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (!bus_if.busy) break;
            cnt++;
        end
        check("t3_busy_len", 32'(cnt), 32'd46);
        check("t3_idle_seg", 32'(bus_if.seg), 32'h06);
        $display("T3 value 80000001 sequence checked");

        bus_if.value = 32'h000000A5;
        tick(2);
        bus_if.value = 32'h00000003;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (!bus_if.busy) break;
        end
        check("t4_idle_gap", dut_obs(), 32'({7'h6D, 1'b0, 1'b0, 3'd0}));
        tick(1);
        check("t4_restart", dut_obs(), 32'({7'h4F, 1'b1, 1'b1, 3'd0}));
        tick(5);
        $display("T4 change during SHOW checked");

        bus_if.value = 32'h000000A5;
        tick(5);
        check("t5_gap", 32'(bus_if.seg), 32'h00);
        bus_if.enable = 1'b0;
        tick(10);
        check("t5_frozen", dut_obs(), 32'({7'h00, 1'b0, 1'b1, 3'd0}));
        bus_if.enable = 1'b1;
        tick(1);
        check("t5_gap_rest", 32'(bus_if.seg), 32'h00);
        tick(1);
        check("t5_resume", dut_obs(), 32'({7'h6D, 1'b0, 1'b1, 3'd0}));
        tick(5);
        bus_if.enable = 1'b0;
        bus_if.value  = 32'h00000007;
        tick(5);
        check("t5_no_sample", dut_obs(), 32'({7'h6D, 1'b0, 1'b0, 3'd0}));
        bus_if.enable = 1'b1;
        tick(1);
        check("t5_sample", dut_obs(), 32'({7'h07, 1'b1, 1'b1, 3'd0}));
        tick(5);
        $display("T5 enable freeze checked");

        bus_if.value = 32'h00000012;
        tick(2);
        check("t6_show", dut_obs(), 32'({7'h06, 1'b1, 1'b1, 3'd1}));
        #2 rst_n = 1'b0;
        #1 check("t6_async_rst", dut_obs(), 32'({7'h3F, 1'b0, 1'b0, 3'd0}));
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("t6_fresh", dut_obs(), 32'({7'h06, 1'b1, 1'b1, 3'd1}));
        tick(12);
        check("t6_done", dut_obs(), 32'({7'h5B, 1'b0, 1'b0, 3'd0}));
        $display("T6 async reset mid-sequence checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
